// File: rtl/inst_fetch_queue.sv
// In-order instruction-fetch queue: issues fetches, buffers returns in a circular queue,
// delivers {inst, addr, pid} beats to decode, and discards responses orphaned by a flush.
module inst_fetch_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int PID_W    = 2,
  parameter int PID_INIT = 2,
  parameter int PID_STEP = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  input  logic              flush_i,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PID_W-1:0]  pid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d, drop_q, drop_d;
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PID_W-1:0]  pid_q;

  logic [PW:0]   used, inflight;
  logic [PW-1:0] alloc_idx, fill_idx, head_idx;
  logic          can_req, accept, discard, head_filled, bypass, deliver;
  logic [DATA_W-1:0] head_data;

  assign used      = alloc_q - head_q;
  assign inflight  = alloc_q - fill_q;
  assign alloc_idx = alloc_q[PW-1:0];
  assign fill_idx  = fill_q[PW-1:0];
  assign head_idx  = head_q[PW-1:0];

  // Responses still owed for flushed requests occupy capacity until they drain.
  assign can_req = ({1'b0, used} + {1'b0, drop_q}) < DEPTH_C;
  assign req_o        = valid_i & ~flush_i & can_req;
  assign fetch_addr_o = addr_i;

  assign accept  = data_ok_i & (drop_q == '0) & (inflight != '0) & ~flush_i;
  assign discard = data_ok_i & ((drop_q != '0) | (flush_i & (inflight != '0)));

  assign head_filled = filled_q[head_idx] & (used != '0);
  assign bypass      = accept & (fill_q == head_q);
  assign deliver     = ready_i & (head_filled | bypass);
  assign ready_o     = deliver & ~flush_i;
  assign head_data   = head_filled ? ent_data_q[head_idx] : rdata_i;

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    drop_d  = drop_q;
    if (flush_i) begin
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      drop_d  = drop_q + inflight - (PW+1)'(discard);
    end else begin
      alloc_d = alloc_q + (PW+1)'(req_o);
      fill_d  = fill_q + (PW+1)'(accept);
      head_d  = head_q + (PW+1)'(ready_o);
      drop_d  = drop_q - (PW+1)'(discard);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      addr_q   <= '0;
      pid_q    <= PID_W'(PID_INIT);
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      drop_q  <= drop_d;
      // alloc and fill slots never alias while both fire: that would need a full queue
      if (req_o)  filled_q[alloc_idx] <= 1'b0;
      if (accept) filled_q[fill_idx]  <= 1'b1;
      valid_q <= ready_o;
      if (ready_o) begin
        inst_q <= head_data;
        addr_q <= ent_addr_q[head_idx];
        pid_q  <= pid_q + PID_W'(PID_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_o)  ent_addr_q[alloc_idx] <= addr_i;
    if (accept) ent_data_q[fill_idx]  <= rdata_i;
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign addr_o  = addr_q;
  assign pid_o   = pid_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, PID_INIT=2, PID_STEP=2).
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i, ready_i, flush_i, data_ok_i;
  logic [31:0] addr_i, rdata_i;
  logic        req_o, ready_o, valid_o;
  logic [31:0] fetch_addr_o, inst_o, addr_o;
  logic [1:0]  pid_o;

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .PID_W(2), .PID_INIT(2), .PID_STEP(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .addr_i(addr_i),
    .ready_i(ready_i), .flush_i(flush_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i),
    .req_o(req_o), .fetch_addr_o(fetch_addr_o), .ready_o(ready_o), .valid_o(valid_o),
    .inst_o(inst_o), .addr_o(addr_o), .pid_o(pid_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] a, input logic dok,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    valid_i = v; addr_i = a; data_ok_i = dok; rdata_i = rd; ready_i = rdy; flush_i = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst_o); end
    checks++; if (addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr_o); end
    checks++; if (pid_o !== 2'd2) begin errors++; $display("FAIL reset_pid got %0d exp 2", pid_o); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if ({req_o, ready_o} !== 2'b00) begin errors++; $display("FAIL reset_idle req/ready got %b exp 00", {req_o, ready_o}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    drive(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_req got %0b exp 1", req_o); end
    checks++; if (fetch_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL single_faddr got %h exp 80000000", fetch_addr_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL single_early_ready got %0b exp 0", ready_o); end
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_bypass_ready got %0b exp 1", ready_o); end
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h13, 32'h8000_0000, 2'd0})
      begin errors++; $display("FAIL single_beat got v=%0b i=%h a=%h p=%0d exp v=1 i=00000013 a=80000000 p=0", valid_o, inst_o, addr_o, pid_o); end
    idle();
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %0b exp 0", valid_o); end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_pid [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL bp_req%0d got %0b exp 1", i, req_o); end
      step();
    end
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bp_full_req got %0b exp 0", req_o); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if ({req_o, valid_o} !== 2'b00) begin errors++; $display("FAIL bp_filled_full req/valid got %b exp 00", {req_o, valid_o}); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready%0d got %0b exp 1", i, ready_o); end
      step();
      checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h100 + 32'(i), 32'(i * 4), exp_pid[i]})
        begin errors++; $display("FAIL bp_beat%0d got v=%0b i=%h a=%h p=%0d exp i=%h a=%h p=%0d", i, valid_o, inst_o, addr_o, pid_o, 32'h100 + 32'(i), 32'(i * 4), exp_pid[i]); end
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_empty_ready got %0b exp 0", ready_o); end
  endtask

  task automatic test_full_simultaneous();
    logic [31:0] exp_inst [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    logic [31:0] exp_addr [4] = '{32'h204, 32'h208, 32'h20C, 32'h210};
    logic [1:0]  exp_pid  [4] = '{2'd2, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h20C, 1'b1, 32'hA2, 1'b1, 1'b0);
    checks++; if ({req_o, ready_o} !== 2'b11) begin errors++; $display("FAIL simul_req_ready got %b exp 11", {req_o, ready_o}); end
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'hA0, 32'h200, 2'd0})
      begin errors++; $display("FAIL simul_beat got v=%0b i=%h a=%h p=%0d exp i=000000a0 a=00000200 p=0", valid_o, inst_o, addr_o, pid_o); end
    drive(1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL simul_last_slot_req got %0b exp 1", req_o); end
    step();
    drive(1'b1, 32'h214, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL simul_full_req got %0b exp 0", req_o); end
    drive(1'b0, 32'h0, 1'b1, 32'hA3, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'hA4, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      step();
      checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, exp_inst[i], exp_addr[i], exp_pid[i]})
        begin errors++; $display("FAIL simul_drain%0d got v=%0b i=%h a=%h p=%0d exp i=%h a=%h p=%0d", i, valid_o, inst_o, addr_o, pid_o, exp_inst[i], exp_addr[i], exp_pid[i]); end
    end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h308, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if ({req_o, ready_o} !== 2'b00) begin errors++; $display("FAIL flush_req_ready got %b exp 00", {req_o, ready_o}); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", valid_o); end
    // two responses still owed: only two more requests fit
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL flush_newreq0 got %0b exp 1", req_o); end
    step();
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL flush_newreq1 got %0b exp 1", req_o); end
    step();
    drive(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL flush_drop_limit got %0b exp 0", req_o); end
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_discard0 got %0b exp 0", ready_o); end
    step();
    drive(1'b0, 32'h0, 1'b1, 32'hBEEF, 1'b1, 1'b0);
    checks++; if ({ready_o, valid_o} !== 2'b00) begin errors++; $display("FAIL flush_discard1 got %b exp 00", {ready_o, valid_o}); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_discard_valid got %0b exp 0", valid_o); end
    drive(1'b0, 32'h0, 1'b1, 32'h55, 1'b1, 1'b0);
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h55, 32'h100, 2'd0})
      begin errors++; $display("FAIL flush_after0 got v=%0b i=%h a=%h p=%0d exp i=00000055 a=00000100 p=0", valid_o, inst_o, addr_o, pid_o); end
    drive(1'b0, 32'h0, 1'b1, 32'h66, 1'b1, 1'b0);
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h66, 32'h104, 2'd2})
      begin errors++; $display("FAIL flush_after1 got v=%0b i=%h a=%h p=%0d exp i=00000066 a=00000104 p=2", valid_o, inst_o, addr_o, pid_o); end
  endtask

  task automatic test_flush_with_dataok();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h11, 1'b1, 1'b0);
    step();
    checks++; if ({valid_o, inst_o, pid_o} !== {1'b1, 32'h11, 2'd0}) begin errors++; $display("FAIL fdo_pre got v=%0b i=%h p=%0d exp v=1 i=00000011 p=0", valid_o, inst_o, pid_o); end
    drive(1'b0, 32'h0, 1'b1, 32'h22, 1'b1, 1'b1);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fdo_flush_ready got %0b exp 0", ready_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fdo_flush_valid got %0b exp 0", valid_o); end
    drive(1'b0, 32'h0, 1'b1, 32'h33, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fdo_discard got %0b exp 0", ready_o); end
    step();
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fdo_drained_ready got %0b exp 1", ready_o); end
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h44, 32'h500, 2'd2})
      begin errors++; $display("FAIL fdo_beat got v=%0b i=%h a=%h p=%0d exp i=00000044 a=00000500 p=2", valid_o, inst_o, addr_o, pid_o); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h77, 1'b1, 1'b0);
    step();
    checks++; if ({valid_o, inst_o, pid_o} !== {1'b1, 32'h77, 2'd0}) begin errors++; $display("FAIL rmid_pre got v=%0b i=%h p=%0d exp v=1 i=00000077 p=0", valid_o, inst_o, pid_o); end
    idle();
    reset_n = 1'b0;
    #1;
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b0, 32'h0, 32'h0, 2'd2})
      begin errors++; $display("FAIL rmid_async got v=%0b i=%h a=%h p=%0d exp v=0 i=0 a=0 p=2", valid_o, inst_o, addr_o, pid_o); end
    step();
    reset_n = 1'b1;
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h88, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rmid_stale got %0b exp 0", ready_o); end
    step();
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h99, 1'b1, 1'b0);
    step();
    checks++; if ({valid_o, inst_o, addr_o, pid_o} !== {1'b1, 32'h99, 32'h700, 2'd0})
      begin errors++; $display("FAIL rmid_restart got v=%0b i=%h a=%h p=%0d exp i=00000099 a=00000700 p=0", valid_o, inst_o, addr_o, pid_o); end
  endtask

  initial begin
    reset_n = 1'b1;
    idle();
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_full_simultaneous();
    test_flush_inflight();
    test_flush_with_dataok();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
